request_latch_ctrl: RTL and testbench
=====================================

REQUEST_LATCH_CTRL -- requirements
Module: request_latch_ctrl

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 8'd15, the number of cycles irq waits for ack before the request is dropped (legal range 1..255).
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 req  input  4  raw request lines; a rising edge on each line is an event.
REQ-005 mask  input  4  per-line capture mask; 1 blocks capture of new events on that line.
REQ-006 pend  output  4  pending-request register; drives D of the downstream 4-to-2 priority encoder.
REQ-007 enc_x  input  2  encoder index output X, returned from the encoder.
REQ-008 enc_v  input  1  encoder valid output V, returned from the encoder.
REQ-009 ack  input  1  consumer acknowledge for the currently presented request.
REQ-010 irq  output  1  request presented to the consumer.
REQ-011 irq_id  output  2  index of the presented request; stable while irq=1.
REQ-012 timeout  output  1  one-cycle pulse when a presented request is dropped.
REQ-013 busy  output  1  high when the state is not IDLE.

Function
REQ-014 The block SHALL register req into req_q each cycle; edge[i] = req[i] & ~req_q[i].
REQ-015 On edge[i] & ~mask[i], pend[i] SHALL be set at that clock edge; masked edges SHALL be discarded and not remembered.
REQ-016 A level held on req SHALL produce exactly one event.
REQ-017 The FSM SHALL have three states: IDLE, PRESENT and DROP, with registered outputs.
REQ-018 IDLE with enc_v=1: irq_id <= enc_x, irq <= 1, counter <= 0, next state PRESENT; with enc_v=0, stay in IDLE.
REQ-019 PRESENT with ack=1: clear pend[irq_id], irq <= 0, next state IDLE.
REQ-020 PRESENT with ack=0: increment the counter; when counter == TIMEOUT-1, clear pend[irq_id], irq <= 0, timeout <= 1, next state DROP.
REQ-021 DROP SHALL last one cycle: timeout <= 0, next state IDLE.
REQ-022 ack SHALL be ignored outside PRESENT.
REQ-023 irq_id SHALL NOT change while irq=1, even if a higher-priority pend bit is set.
REQ-024 Events arriving during PRESENT or DROP SHALL be captured into pend and serviced after the return to IDLE.
REQ-025 If a clear of pend[i] and an unmasked edge on line i occur in the same cycle, set SHALL win and pend[i] SHALL stay 1.
REQ-026 Latency: an edge sampled at clock k SHALL set pend at k; irq SHALL assert at k+1 if the FSM is in IDLE.
REQ-027 Back-to-back service: after ack at clock k, the FSM is in IDLE at k+1 and irq re-asserts at k+2 if pend is nonzero.
REQ-028 The counter SHALL be 8 bits wide and SHALL NOT wrap within a single presentation.
REQ-029 A mask change SHALL NOT clear bits that are already pending.

Reset
REQ-030 While rst_n=0 at a clock edge, the block SHALL set pend=0, req_q=0, irq=0, irq_id=0, timeout=0, busy=0, counter=0 and state IDLE.
REQ-031 Reset asserted mid-PRESENT SHALL abort without a timeout pulse.
REQ-032 After reset, a req line already high SHALL count as an edge on the first cycle out of reset, because req_q=0.

Verification
(Bench connects pend to the existing 4-to-2 priority encoder, bit 3 highest.)
REQ-033 req=4'b0100 held, mask=0 -> pend=0100 next edge; irq=1 and irq_id=2 one cycle later; ack -> pend=0000 and irq=0; no second event while req stays high.
REQ-034 req edges on 4'b1010 in the same cycle -> irq_id=3 served first; after ack, irq_id=1 at ack+2 cycles.
REQ-035 irq_id=1 presented, then an edge on line 3 -> irq_id stays 1 until ack, then line 3 is served.
REQ-036 TIMEOUT=4, no ack -> irq high for 4 cycles, a single timeout pulse, pend bit cleared, busy low one cycle after the pulse.
REQ-037 mask=4'b0001 with an edge on line 0 -> pend stays 0000; line 0 held high while mask drops -> still no event.
REQ-038 Same-cycle ack of line 2 and a new edge on line 2 -> pend[2]=1, and line 2 is re-presented.

Source files
------------

// File: rtl/request_latch_ctrl_if.sv
// request_latch_ctrl_if: request capture, encoder return and consumer handshake bundle
interface request_latch_ctrl_if;
   logic [3:0] req;
   logic [3:0] mask;
   logic [3:0] pend;
   logic [1:0] enc_x;
   logic       enc_v;
   logic       ack;
   logic       irq;
   logic [1:0] irq_id;
   logic       timeout;
   logic       busy;
   modport master (output req, mask, enc_x, enc_v, ack, input pend, irq, irq_id, timeout, busy);
   modport slave (input req, mask, enc_x, enc_v, ack, output pend, irq, irq_id, timeout, busy);
endinterface

// File: rtl/request_latch_ctrl.sv
// request_latch_ctrl: edge-captured request latch presenting encoded requests with ack/timeout
module request_latch_ctrl #(
   parameter logic [7:0] TIMEOUT = 8'd15
) (
   input logic clk,
   input logic rst_n,
   request_latch_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PRESENT, DROP} state_t;
   state_t     state, state_n;
   logic [3:0] req_q, pend, clr, set_v;
   logic [7:0] cnt, cnt_n;
   logic [1:0] irq_id, irq_id_n;
   logic       irq, irq_n, timeout, timeout_n;
   assign set_v = bus.req & ~req_q & ~bus.mask;
   // next-state and next registered outputs; clr drops the served line on ack or expiry
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      irq_n     = irq;
      irq_id_n  = irq_id;
      timeout_n = 1'b0;
      clr       = '0;
      case (state)
         IDLE: if (bus.enc_v) begin
            state_n  = PRESENT;
            irq_n    = 1'b1;
            irq_id_n = bus.enc_x;
            cnt_n    = '0;
         end
         PRESENT: if (bus.ack) begin
            clr     = 4'b0001 << irq_id;
            irq_n   = 1'b0;
            state_n = IDLE;
         end else if (cnt == TIMEOUT - 8'd1) begin
            clr       = 4'b0001 << irq_id;
            irq_n     = 1'b0;
            timeout_n = 1'b1;
            state_n   = DROP;
         end else begin
            cnt_n = cnt + 8'd1;
         end
         default: state_n = IDLE;
      endcase
   end
   // state, counter, outputs and pend register; a new edge beats a same-cycle clear
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         req_q   <= '0;
         pend    <= '0;
         cnt     <= '0;
         irq     <= 1'b0;
         irq_id  <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_n;
         req_q   <= bus.req;
         pend    <= (pend & ~clr) | set_v;
         cnt     <= cnt_n;
         irq     <= irq_n;
         irq_id  <= irq_id_n;
         timeout <= timeout_n;
      end
   end
   assign bus.pend    = pend;
   assign bus.irq     = irq;
   assign bus.irq_id  = irq_id;
   assign bus.timeout = timeout;
   assign bus.busy    = state != IDLE;
endmodule

// File: tb/tb_request_latch_ctrl.sv
// tb_request_latch_ctrl: directed vector bench with a 4-to-2 priority encoder on pend
module tb_request_latch_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_bad = 0;
   request_latch_ctrl_if bus ();
   request_latch_ctrl #(.TIMEOUT(8'd4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   assign bus.enc_v = |bus.pend;
   assign bus.enc_x = bus.pend[3] ? 2'd3 : bus.pend[2] ? 2'd2 : bus.pend[1] ? 2'd1 : 2'd0;
   typedef struct {
      logic       r;
      logic [3:0] req;
      logic [3:0] mask;
      logic       ack;
      logic [3:0] pend;
      logic       irq;
      logic [1:0] id;
      logic       to;
      logic       busy;
   } vec_t;
   vec_t tbl[20];
   task automatic step(input string nm, input logic r, input logic [3:0] rq, input logic [3:0] mk,
                       input logic a, input logic [3:0] e_pend, input logic e_irq,
                       input logic [1:0] e_id, input logic e_to, input logic e_busy);
      logic [8:0] got, exp;
      rst_n    = r;
      bus.req  = rq;
      bus.mask = mk;
      bus.ack  = a;
      @(posedge clk);
      #1;
      n_vec++;
      got = {bus.pend, bus.irq, bus.irq_id, bus.timeout, bus.busy};
      exp = {e_pend, e_irq, e_id, e_to, e_busy};
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got pend=%b irq=%b id=%0d to=%b busy=%b, expected pend=%b irq=%b id=%0d to=%b busy=%b",
                  nm, got[8:5], got[4], got[3:2], got[1], got[0], e_pend, e_irq, e_id, e_to, e_busy);
      end
   endtask
   initial begin
      tbl[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b0, 2'd2, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b1, 2'd3, 1'b0, 1'b1};
      tbl[9]  = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd3, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b1, 2'd1, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd1, 1'b0, 1'b0};
      tbl[14] = '{1'b1, 4'b1010, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1};
      tbl[15] = '{1'b1, 4'b1010, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
      tbl[16] = '{1'b1, 4'b0000, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
      tbl[17] = '{1'b1, 4'b0001, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
      tbl[18] = '{1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
      tbl[19] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0, 1'b0};
      for (int i = 0; i < 20; i++)
         step($sformatf("tbl%0d", i), tbl[i].r, tbl[i].req, tbl[i].mask, tbl[i].ack,
              tbl[i].pend, tbl[i].irq, tbl[i].id, tbl[i].to, tbl[i].busy);
      // TIMEOUT=4 expiry on line 0: irq high four samples, one timeout pulse, then idle
      step("to_capture", 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd3, 1'b0, 1'b0);
      step("to_present", 1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1);
      step("to_wait1",   1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1);
      step("to_wait2",   1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1);
      step("to_wait3",   1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1'b1);
      step("to_pulse",   1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 1'b1);
      step("to_idle",    1'b1, 4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      // ack and a new edge on the same line in one cycle: set wins, line re-presented
      step("sc_low",     1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      step("sc_edge",    1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
      step("sc_present", 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
      step("sc_ackedge", 1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b0, 1'b0);
      step("sc_repres",  1'b1, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 1'b1);
      step("sc_ack",     1'b1, 4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 1'b0);
      // reset mid-presentation, a line high out of reset, ack ignored in idle, mask keeps pend
      step("rs_edge",    1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd2, 1'b0, 1'b0);
      step("rs_present", 1'b1, 4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0, 1'b1);
      step("rs_abort",   1'b0, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      step("rs_hold",    1'b0, 4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      step("rs_first",   1'b1, 4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
      step("rs_present", 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1);
      step("rs_mask",    1'b1, 4'b0010, 4'b1111, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
